// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: accepts one
// operation at a time, waits ALU_LAT cycles, and returns the result to its owner.
module alu_req_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [3:0] req0_a_i,
    input  logic [3:0] req0_b_i,
    input  logic [1:0] req0_c_i,
    input  logic [1:0] req0_opcode_i,
    input  logic [1:0] req0_inmode_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [3:0] req1_a_i,
    input  logic [3:0] req1_b_i,
    input  logic [1:0] req1_c_i,
    input  logic [1:0] req1_opcode_i,
    input  logic [1:0] req1_inmode_i,
    output logic       rsp0_valid_o,
    input  logic       rsp0_ready_i,
    output logic [9:0] rsp0_result_o,
    output logic       rsp1_valid_o,
    input  logic       rsp1_ready_i,
    output logic [9:0] rsp1_result_o,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [1:0] alu_c_o,
    output logic [1:0] alu_opcode_o,
    output logic [1:0] alu_inmode_o,
    input  logic [9:0] alu_result_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0] alu_c_q, alu_c_d, alu_opcode_q, alu_opcode_d, alu_inmode_q, alu_inmode_d;
    logic [9:0] rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
    logic [1:0] rsp_valid_q, rsp_valid_d;
    logic       busy_q;
    logic       grant_s, handshake_s, owner_rsp_ready_s;

    // Grant selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_s = ~last_grant_q;
        end else begin
            grant_s = req1_valid_i;
        end
    end

    assign req0_ready_o      = (state_q == ST_IDLE) && !grant_s && req0_valid_i;
    assign req1_ready_o      = (state_q == ST_IDLE) &&  grant_s && req1_valid_i;
    assign handshake_s       = req0_ready_o || req1_ready_o;
    assign owner_rsp_ready_s = owner_q ? rsp1_ready_i : rsp0_ready_i;

    // Next-state logic for the issue/wait/respond sequence.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_c_d       = alu_c_q;
        alu_opcode_d  = alu_opcode_q;
        alu_inmode_d  = alu_inmode_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        rsp_valid_d   = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_d      = ST_WAIT;
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    cnt_d        = LAT_CNT;
                    alu_a_d      = grant_s ? req1_a_i      : req0_a_i;
                    alu_b_d      = grant_s ? req1_b_i      : req0_b_i;
                    alu_c_d      = grant_s ? req1_c_i      : req0_c_i;
                    alu_opcode_d = grant_s ? req1_opcode_i : req0_opcode_i;
                    alu_inmode_d = grant_s ? req1_inmode_i : req0_inmode_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (owner_q) begin
                        rsp1_result_d = alu_result_i;
                        rsp_valid_d   = 2'b10;
                    end else begin
                        rsp0_result_d = alu_result_i;
                        rsp_valid_d   = 2'b01;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (owner_rsp_ready_s) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 2'b00;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= 4'd0;
            alu_a_q       <= 4'd0;
            alu_b_q       <= 4'd0;
            alu_c_q       <= 2'd0;
            alu_opcode_q  <= 2'd0;
            alu_inmode_q  <= 2'd0;
            rsp0_result_q <= 10'd0;
            rsp1_result_q <= 10'd0;
            rsp_valid_q   <= 2'b00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_c_q       <= alu_c_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_inmode_q  <= alu_inmode_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp_valid_q   <= rsp_valid_d;
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign rsp0_valid_o  = rsp_valid_q[0];
    assign rsp1_valid_o  = rsp_valid_q[1];
    assign rsp0_result_o = rsp0_result_q;
    assign rsp1_result_o = rsp1_result_q;
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_c_o       = alu_c_q;
    assign alu_opcode_o  = alu_opcode_q;
    assign alu_inmode_o  = alu_inmode_q;
    assign busy_o        = busy_q;

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin controller that shares one 4-bit ALU datapath (operands a/b, carry/aux c, opcode, inmode, 10-bit result) between two independent requesters. It accepts one operation at a time over a valid/ready handshake and drives the registered operands into the ALU. After a fixed, parameterised ALU latency it captures the 10-bit result and returns it to the originating requester over a second valid/ready handshake. It sits between the top-level pin decode and the ALU instance, replacing direct pin-to-ALU wiring.

## Interface
- ALU_LAT, 1, cycles from operands presented on alu_* to alu_result valid; legal range 0..15 (0 = purely combinational ALU)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_a, req0_b  in  4 each  operands
- req0_c  in  2  aux/carry field
- req0_opcode  in  2  ALU opcode
- req0_inmode  in  2  ALU input mode
- req1_valid, req1_ready, req1_a, req1_b, req1_c, req1_opcode, req1_inmode: same as requester 0
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp0_result  out  10  result for requester 0
- rsp1_valid, rsp1_ready, rsp1_result: same as requester 0
- alu_a, alu_b  out  4 each  registered operands to ALU
- alu_c, alu_opcode, alu_inmode  out  2 each  registered controls to ALU
- alu_result  in  10  ALU result
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant selection is combinational from reqN_valid and last_grant (1 bit). If only one requester is valid, it is granted. If both are valid, the requester not equal to last_grant is granted.
  - reqN_ready = (state==IDLE) && (grant==N) && reqN_valid. Only one ready is ever high.
  - On handshake: latch the granted operand/control fields into alu_*, set owner=grant, last_grant=grant, load cnt=ALU_LAT, and go to WAIT.
- WAIT: if cnt==0, sample alu_result into the result register and go to RESP; otherwise decrement cnt.
- RESP:
  - rsp[owner]_valid=1 and rsp[owner]_result = captured value. The other rsp_valid stays 0.
  - On rsp[owner]_ready go to IDLE.
  - The result and valid hold stable while ready is low; there is no timeout.
- alu_* hold the last issued operation after completion. They change only on a request handshake.
- rspN_result holds its last value after the response handshake.
- reqN_* field changes while reqN_ready=0 are ignored.
- No arithmetic in this block: the result is passed through bit-exact at 10 bits.

## Timing
- Reset (rst sampled high), all outputs:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), owner=0, cnt=0.
  - alu_a=alu_b=0, alu_c=alu_opcode=alu_inmode=0.
  - rsp0_valid=rsp1_valid=0, rsp0_result=rsp1_result=0, busy=0.
  - reqN_ready follows the IDLE rule from the cycle after reset deasserts.
- Request handshake in cycle T:
  - alu_* show the new operands from T+1.
  - alu_result is sampled at the edge ending cycle T+1+ALU_LAT.
  - rspN_valid is high from T+2+ALU_LAT.
- Response handshake in cycle R: the state is IDLE in R+1, and a new request can be accepted in R+1.
- Minimum issue interval is ALU_LAT+3 cycles.
- Reset mid-operation (WAIT or RESP): the operation is discarded, no response is produced, and all registers take their reset values on that edge.
- Simultaneous reqN_valid arrival: arbitration per the last_grant rule. The loser keeps valid asserted and is served on the next IDLE.
- A requester may assert reqN_valid while its own response is pending; it is not accepted until IDLE.

## Test plan
The bench ALU stub returns {c,a,b} delayed by ALU_LAT registers.
- Single op, ALU_LAT=1: req0 a=3, b=5, c=2, opcode=1, inmode=0 handshake at T -> alu_a=3/alu_b=5 at T+1; rsp0_valid at T+3 with rsp0_result=10'b10_0011_0101; rsp1_valid stays 0.
- Tie after reset: both valid at T with req0 a=1 and req1 a=2 -> req0_ready at T and rsp0_result[7:4]=1. Then req1 is accepted at the first IDLE cycle and rsp1_result[7:4]=2. Next tie goes to req0 (alternation).
- Response backpressure: hold rsp0_ready=0 for 5 cycles -> rsp0_valid and rsp0_result stable, busy=1, req1_ready=0 throughout. Raise ready -> IDLE the next cycle.
- Reset mid-WAIT with ALU_LAT=4: assert rst 2 cycles after handshake -> no rspN_valid ever; alu_*=0 and busy=0 after the edge; last_grant=1.
- ALU_LAT=0, back-to-back req1 ops with rsp1_ready tied high -> accepts 3 cycles apart, each result matching the stub.
- Field changes while not ready: alter req0_a while req0_ready=0 -> alu_a unchanged until handshake.
